// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the writeback stage and its neighbours.
//
// Contents:
//   wb_state_e   - writeback FSM states (RUN, HALTED)
//   WB_MAX_LANES - largest supported retire width
//   wb_lane_t    - per-lane retire fields, for upstream stages that build bundles
//   wb_popcount  - number of set bits in a lane mask
package cpu_defs;

    localparam int WB_MAX_LANES = 4;
    localparam int WB_REG_IDX_W = 5;
    localparam int WB_DATA_W    = 32;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic                    valid;
        logic [WB_REG_IDX_W-1:0] rd;
        logic                    is_wr_rd;
        logic                    is_wr_rd_pc_plus4;
        logic [WB_DATA_W-1:0]    pc;
        logic [WB_DATA_W-1:0]    pc_plus4;
        logic [WB_DATA_W-1:0]    ex_mem_out;
        logic                    is_halt;
    } wb_lane_t;

    function automatic int unsigned wb_popcount(input logic [WB_MAX_LANES-1:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WB_MAX_LANES; i++) begin
            n = n + 32'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/commit_counters.sv
// 64-bit cycle and retired-instruction counters for the writeback stage.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - stage is running; both counters freeze when low
//   inc        - number of instructions committed this cycle
//   cycle_cnt  - cycles spent running (wraps modulo 2^64)
//   instr_cnt  - committed instructions (wraps modulo 2^64)
module commit_counters
    import cpu_defs::*;
#(
    parameter int LANES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [$clog2(LANES+1)-1:0]   inc,
    output logic [63:0]                  cycle_cnt,
    output logic [63:0]                  instr_cnt
);

    // Both counters advance together only while the stage is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (en) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            instr_cnt <= instr_cnt + 64'(inc);
        end
    end

endmodule

// File: rtl/writeback_multi.sv
// Multi-lane writeback stage. Registers a bundle of up to LANES in-order
// retiring instructions (lane 0 oldest) and drives one register-file write
// port per lane. Same-destination writes inside a bundle are resolved in
// favour of the youngest lane. A committing halt instruction moves the stage
// to HALTED, latching its code and pc; only reset leaves HALTED.
//
// Build option: define WB_COMMIT_TRACE_EN to add the cmt_* commit trace
// outputs (registered copies of commit/pc/write port, one cycle late).
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - kill current stage contents
//   next_rdy_in          - downstream ready
//   rdy_in               - stage can accept a bundle
//   in_*                 - per-lane bundle fields from memory2
//   reg_we/idx/data      - per-lane register-file write ports
//   trap, trap_code, trap_pc - halt status and latched halt info
//   cycle_cnt, instr_cnt - running-cycle and committed-instruction counters
//   cmt_*                - commit trace (WB_COMMIT_TRACE_EN only)
module writeback_multi
    import cpu_defs::*;
#(
    parameter int LANES     = 2,
    parameter int REG_IDX_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              next_rdy_in,
    output logic                              rdy_in,
    input  logic [LANES-1:0]                  in_valid,
    input  logic [LANES-1:0][REG_IDX_W-1:0]   in_rd,
    input  logic [LANES-1:0]                  in_is_wr_rd,
    input  logic [LANES-1:0]                  in_is_wr_rd_pc_plus4,
    input  logic [LANES-1:0][DATA_W-1:0]      in_pc,
    input  logic [LANES-1:0][DATA_W-1:0]      in_pc_plus4,
    input  logic [LANES-1:0][DATA_W-1:0]      in_ex_mem_out,
    input  logic [LANES-1:0]                  in_is_halt,
    output logic [LANES-1:0]                  reg_we,
    output logic [LANES-1:0][REG_IDX_W-1:0]   reg_idx,
    output logic [LANES-1:0][DATA_W-1:0]      reg_data,
    output logic                              trap,
    output logic [7:0]                        trap_code,
    output logic [DATA_W-1:0]                 trap_pc,
    output logic [63:0]                       cycle_cnt,
    output logic [63:0]                       instr_cnt
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic [LANES-1:0]                  cmt_valid,
    output logic [LANES-1:0][DATA_W-1:0]      cmt_pc,
    output logic [LANES-1:0]                  cmt_wen,
    output logic [LANES-1:0][REG_IDX_W-1:0]   cmt_wdest,
    output logic [LANES-1:0][DATA_W-1:0]      cmt_wdata
`endif
);

    localparam int INC_W = $clog2(LANES + 1);

    wb_state_e                       state;

    logic [LANES-1:0]                valid_r;
    logic [LANES-1:0][REG_IDX_W-1:0] rd_r;
    logic [LANES-1:0]                is_wr_rd_r;
    logic [LANES-1:0]                sel_pc4_r;
    logic [LANES-1:0][DATA_W-1:0]    pc_r;
    logic [LANES-1:0][DATA_W-1:0]    pc_plus4_r;
    logic [LANES-1:0][DATA_W-1:0]    result_r;
    logic [LANES-1:0]                halt_r;

    logic                            stage_flush;
    logic [LANES-1:0]                commit;
    logic [LANES-1:0]                base_we;
    logic                            halt_seen;
    logic                            halt_found;
    logic [7:0]                      halt_code_nxt;
    logic [DATA_W-1:0]               halt_pc_nxt;
    logic [INC_W-1:0]                commit_inc;

    // An empty or flushed stage, a ready consumer, or a halted stage (which
    // only drains) all allow the next bundle in.
    assign stage_flush = flush | ~|valid_r;
    assign rdy_in      = stage_flush | next_rdy_in | (state == HALTED);

    // Input register: whole bundle captured whenever the stage accepts one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= '0;
            rd_r       <= '0;
            is_wr_rd_r <= '0;
            sel_pc4_r  <= '0;
            pc_r       <= '0;
            pc_plus4_r <= '0;
            result_r   <= '0;
            halt_r     <= '0;
        end else if (rdy_in) begin
            valid_r    <= in_valid;
            rd_r       <= in_rd;
            is_wr_rd_r <= in_is_wr_rd;
            sel_pc4_r  <= in_is_wr_rd_pc_plus4;
            pc_r       <= in_pc;
            pc_plus4_r <= in_pc_plus4;
            result_r   <= in_ex_mem_out;
            halt_r     <= in_is_halt;
        end
    end

    // A lane commits only if no older lane in the bundle is a halt; the halt
    // lane itself still commits.
    always_comb begin
        commit    = '0;
        halt_seen = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            commit[k] = valid_r[k] & ~flush & next_rdy_in & (state == RUN) & ~halt_seen;
            halt_seen = halt_seen | (valid_r[k] & halt_r[k]);
        end
    end

    // Write ports: drop an older lane's write when a younger committing lane
    // targets the same register, so the regfile sees only the final value.
    always_comb begin
        base_we = '0;
        reg_we  = '0;
        for (int k = 0; k < LANES; k++) begin
            base_we[k]  = commit[k] & is_wr_rd_r[k] & (rd_r[k] != '0);
            reg_idx[k]  = rd_r[k];
            reg_data[k] = sel_pc4_r[k] ? pc_plus4_r[k] : result_r[k];
        end
        reg_we = base_we;
        for (int k = 0; k < LANES; k++) begin
            for (int j = k + 1; j < LANES; j++) begin
                if (base_we[j] && (rd_r[j] == rd_r[k])) begin
                    reg_we[k] = 1'b0;
                end
            end
        end
    end

    // Halt info comes from the oldest committing halt lane.
    always_comb begin
        halt_found    = 1'b0;
        halt_code_nxt = '0;
        halt_pc_nxt   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (commit[k] && halt_r[k] && !halt_found) begin
                halt_found    = 1'b1;
                halt_code_nxt = result_r[k][7:0];
                halt_pc_nxt   = pc_r[k];
            end
        end
    end

    // RUN/HALTED state with registered trap outputs; HALTED is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            trap      <= 1'b0;
            trap_code <= '0;
            trap_pc   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_found) begin
                        state     <= HALTED;
                        trap      <= 1'b1;
                        trap_code <= halt_code_nxt;
                        trap_pc   <= halt_pc_nxt;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign commit_inc = INC_W'(wb_popcount(WB_MAX_LANES'(commit)));

    commit_counters #(
        .LANES (LANES)
    ) u_counters (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == RUN),
        .inc       (commit_inc),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

`ifdef WB_COMMIT_TRACE_EN
    // Commit trace for difftest: everything the regfile saw, one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmt_valid <= '0;
            cmt_pc    <= '0;
            cmt_wen   <= '0;
            cmt_wdest <= '0;
            cmt_wdata <= '0;
        end else begin
            cmt_valid <= commit;
            cmt_pc    <= pc_r;
            cmt_wen   <= reg_we;
            cmt_wdest <= reg_idx;
            cmt_wdata <= reg_data;
        end
    end
`endif

endmodule
